// File: rtl/seq_pkg.sv
// Shared encodings for the sequence generator: the term-mode select and the
// control FSM states.
package seq_pkg;

  typedef enum logic [1:0] {
    MODO_CONST = 2'd0,
    MODO_CONT  = 2'd1,
    MODO_FIB   = 2'd2,
    MODO_POT2  = 2'd3
  } modo_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_gen_if.sv
// Request/stream bundle between seq_gen and its controller/consumer.
// The master side issues runs and consumes terms; seq_gen is the slave.
interface seq_gen_if #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic              start;
  logic [1:0]        modo;
  logic [LEN_W-1:0]  comprimento;
  logic [SIZE-1:0]   saida;
  logic              saida_valid;
  logic              saida_ready;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              done;

  modport master (
    output start, modo, comprimento, saida_ready,
    input  saida, saida_valid, address, busy, done
  );

  modport slave (
    input  start, modo, comprimento, saida_ready,
    output saida, saida_valid, address, busy, done
  );
endinterface

// File: rtl/seq_term.sv
// Combinational next-term logic: given the term at index n and the one before
// it, produce the term at index n+1 (all arithmetic modulo 2^SIZE).
module seq_term
  import seq_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 4
) (
  input  modo_t             modo,
  input  logic [ADDR_W-1:0] n,
  input  logic [SIZE-1:0]   term,
  input  logic [SIZE-1:0]   prev,
  output logic [SIZE-1:0]   next
);

  logic [ADDR_W:0] nn;

  always_comb begin
    nn   = {1'b0, n} + 1'b1;
    next = SIZE'(1);
    case (modo)
      MODO_CONST: next = SIZE'(1);
      MODO_CONT:  next = term + 1'b1;
      MODO_FIB:   next = term + prev;
      // Shifting past the term width yields 0, which is the required value.
      MODO_POT2:  next = SIZE'(1) << nn;
      default:    next = SIZE'(1);
    endcase
  end

endmodule

// File: rtl/seq_gen.sv
// Sequence generator: latches mode/length on start, then streams one term per
// accepted handshake and pulses done once the last term is taken.
module seq_gen
  import seq_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int DEPTH = 16
) (
  input logic      clk,
  input logic      rst,
  seq_gen_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = $clog2(DEPTH + 1);

  state_t            state, state_n;
  modo_t             modo_r;
  logic [ADDR_W-1:0] address_r;
  logic [ADDR_W-1:0] last_r;
  logic [ADDR_W-1:0] last_in;
  logic [SIZE-1:0]   term_r;
  logic [SIZE-1:0]   prev_r;
  logic [SIZE-1:0]   next_term;
  logic              hs;
  logic              is_last;

  assign hs      = (state == RUN) && bus.saida_ready;
  assign is_last = (address_r == last_r);

  always_comb begin
    last_in = ADDR_W'(DEPTH - 1);
    if (bus.comprimento != '0 && bus.comprimento <= LEN_W'(DEPTH))
      last_in = ADDR_W'(bus.comprimento - 1'b1);
  end

  seq_term #(
    .SIZE  (SIZE),
    .ADDR_W(ADDR_W)
  ) u_term (
    .modo(modo_r),
    .n   (address_r),
    .term(term_r),
    .prev(prev_r),
    .next(next_term)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = RUN;
      RUN:     if (hs && is_last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Term 0 is 1 in every mode, so a run starts from a constant; clearing prev
  // makes the first Fibonacci step yield F(1)=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      modo_r    <= MODO_CONST;
      last_r    <= '0;
      address_r <= '0;
      term_r    <= '0;
      prev_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            modo_r    <= modo_t'(bus.modo);
            last_r    <= last_in;
            address_r <= '0;
            term_r    <= SIZE'(1);
            prev_r    <= '0;
          end
        end
        RUN: begin
          if (hs && !is_last) begin
            address_r <= address_r + 1'b1;
            term_r    <= next_term;
            prev_r    <= term_r;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.saida       = term_r;
  assign bus.saida_valid = (state == RUN);
  assign bus.address     = address_r;
  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);

  a_done_single: assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |=> (state == IDLE));

endmodule
